// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : fetch_unit
// Description : MIPS instruction fetch stage. Holds the PC, fetches one word
//               per request/ready handshake and advances on downstream ack.
// Revision    : 1.0 - initial release
// =============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic [31:0] w_pcplus4;
    logic [31:0] w_offset_x4;
    logic [31:0] w_pc_next;
    logic        w_load;
    logic        w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs decode the state only, so no input reaches an output.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    w_advance    = 1'b1;
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_pcplus4   = r_pc + 32'd4;
    assign w_offset_x4 = branch_offset << 2;
    assign w_pc_next   = (branch && zero) ? (w_pcplus4 + w_offset_x4) : w_pcplus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            if (w_load) begin
                r_instr <= imem_rdata;
            end
            if (w_advance) begin
                r_pc      <= w_pc_next;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // The PC only moves on ack, so it is also the address of the presented word.
    assign imem_addr = r_pc;
    assign pc_out    = r_pc;
    assign pcplus4   = w_pcplus4;
    assign instr     = r_instr;
    assign opcode    = r_instr[31:26];
    assign funct     = r_instr[5:0];
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with an expected-fetch queue.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req, imem_ready, instr_valid, instr_ack, branch, zero;
    logic [31:0] imem_addr, imem_rdata, instr, pc_out, pcplus4, branch_offset, retired;
    logic [5:0]  opcode, funct;

    logic        w_imem_req, w_imem_ready, w_instr_valid, w_instr_ack, w_branch, w_zero;
    logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_pc_out, w_pcplus4, w_branch_offset, w_retired;
    logic [5:0]  w_opcode, w_funct;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out), .pcplus4(pcplus4),
        .instr_ack(instr_ack), .branch(branch), .zero(zero),
        .branch_offset(branch_offset), .retired(retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata), .instr_valid(w_instr_valid),
        .instr(w_instr), .opcode(w_opcode), .funct(w_funct), .pc_out(w_pc_out),
        .pcplus4(w_pcplus4), .instr_ack(w_instr_ack), .branch(w_branch), .zero(w_zero),
        .branch_offset(w_branch_offset), .retired(w_retired)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_retired;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0000_0020;
        return {a[15:0] ^ 16'h1357, a[15:0] ^ 16'hBEEF};
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e.pc   = 32'hFFFF_FFFF;
        e.word = 32'hFFFF_FFFF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Zero-wait memory: answers the pending request at this negedge.
    task automatic serve(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            exp_q.push_back('{pc: imem_addr, word: mem_word(imem_addr)});
            @(negedge clk);
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_ack(input logic br, input logic z, input logic [31:0] off);
        instr_ack     = 1'b1;
        branch        = br;
        zero          = z;
        branch_offset = off;
        @(negedge clk);
        instr_ack     = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        branch_offset = 32'h0;
        exp_retired   = exp_retired + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ready = 1'b0; imem_rdata = 32'h0; instr_ack = 1'b0;
        branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
        w_imem_ready = 1'b0; w_imem_rdata = 32'h0; w_instr_ack = 1'b0;
        w_branch = 1'b0; w_zero = 1'b0; w_branch_offset = 32'h0;
        exp_retired = 32'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            opcode !== 6'h0 || funct !== 6'h0 || pc_out !== 32'h0 || pcplus4 !== 32'h4 || retired !== 32'h0) begin
            fails++;
            $display("FAIL reset_values got req=%b addr=%h v=%b instr=%h pc=%h p4=%h ret=%0d want 0,0,0,0,0,4,0",
                     imem_req, imem_addr, instr_valid, instr, pc_out, pcplus4, retired);
        end
        tests++;
        if (w_imem_addr !== 32'hFFFF_FFFC || w_pc_out !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin
            fails++;
            $display("FAIL reset_wrap_values got addr=%h pc=%h p4=%h want fffffffc fffffffc 0",
                     w_imem_addr, w_pc_out, w_pcplus4);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_first_req got req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_seq_fetch();
        bit   ok;
        exp_t e;
        serve(ok);
        e = pop_exp();
        tests++;
        if (!ok || e.pc !== 32'h0 || instr_valid !== 1'b1 || instr !== e.word || pc_out !== e.pc ||
            pcplus4 !== 32'h4 || opcode !== 6'b001000) begin
            fails++;
            $display("FAIL seq_fetch0 got ok=%0d v=%b instr=%h pc=%h p4=%h op=%b want 1 20080005 0 4 001000",
                     ok, instr_valid, instr, pc_out, pcplus4, opcode);
        end
        do_ack(1'b0, 1'b1, $urandom);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL seq_next_addr got req=%b addr=%h v=%b want 1 4 0", imem_req, imem_addr, instr_valid);
        end
        serve(ok);
        e = pop_exp();
        tests++;
        if (!ok || instr !== e.word || pc_out !== 32'h4 || opcode !== 6'b000000 || funct !== 6'b100000) begin
            fails++;
            $display("FAIL seq_fetch1 got instr=%h pc=%h op=%b fn=%b want 00000020 4 000000 100000",
                     instr, pc_out, opcode, funct);
        end
        do_ack(1'b0, 1'b0, 32'h0);
        tests++;
        if (retired !== 32'd2 || imem_addr !== 32'h8 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL seq_retired got ret=%0d addr=%h req=%b want 2 8 1", retired, imem_addr, imem_req);
        end
    endtask

    task automatic test_wait_states();
        bit          ok;
        exp_t        e;
        logic [31:0] a;
        a = imem_addr;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            instr_ack = (i == 1);
            branch = 1'b1; zero = 1'b1; branch_offset = 32'h100;
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || imem_addr !== a || instr_valid !== 1'b0 ||
                retired !== exp_retired) begin
                fails++;
                $display("FAIL wait_stable[%0d] got req=%b addr=%h v=%b ret=%0d want 1 8 0 %0d",
                         i, imem_req, imem_addr, instr_valid, retired, exp_retired);
            end
        end
        instr_ack = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
        serve(ok);
        e = pop_exp();
        tests++;
        if (!ok || instr_valid !== 1'b1 || instr !== e.word || pc_out !== 32'h8) begin
            fails++;
            $display("FAIL wait_valid got v=%b instr=%h pc=%h want 1 %h 8", instr_valid, instr, pc_out, e.word);
        end
        do_ack(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_stall();
        bit   ok;
        exp_t e;
        serve(ok);
        e = pop_exp();
        for (int i = 0; i < 5; i++) begin
            instr_ack = 1'b0;
            imem_ready = 1'b1; imem_rdata = ~e.word;
            branch = 1'b1; zero = 1'b1; branch_offset = 32'h40;
            @(negedge clk);
            tests++;
            if (!ok || instr !== e.word || pc_out !== 32'hC || instr_valid !== 1'b1 || imem_req !== 1'b0 ||
                retired !== exp_retired) begin
                fails++;
                $display("FAIL stall_hold[%0d] got instr=%h pc=%h v=%b req=%b ret=%0d want %h c 1 0 %0d",
                         i, instr, pc_out, instr_valid, imem_req, retired, e.word, exp_retired);
            end
        end
        imem_ready = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
        do_ack(1'b0, 1'b0, 32'h0);
        tests++;
        if (imem_addr !== 32'h10 || retired !== exp_retired) begin
            fails++;
            $display("FAIL stall_release got addr=%h ret=%0d want 10 %0d", imem_addr, retired, exp_retired);
        end
    endtask

    task automatic test_branch();
        bit   ok;
        exp_t e;
        serve(ok);
        e = pop_exp();
        tests++;
        if (!ok || pc_out !== 32'h10 || instr !== e.word) begin
            fails++;
            $display("FAIL br_present got pc=%h instr=%h want 10 %h", pc_out, instr, e.word);
        end
        do_ack(1'b1, 1'b1, 32'hFFFF_FFFE);
        tests++;
        if (imem_addr !== 32'hC || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL br_taken got addr=%h req=%b want c 1", imem_addr, imem_req);
        end
        serve(ok);
        void'(pop_exp());
        do_ack(1'b0, 1'b1, 32'hFFFF_FFFE);
        serve(ok);
        e = pop_exp();
        do_ack(1'b1, 1'b0, 32'hFFFF_FFFE);
        tests++;
        if (!ok || e.pc !== 32'h10 || imem_addr !== 32'h14) begin
            fails++;
            $display("FAIL br_not_taken got from=%h addr=%h want 10 14", e.pc, imem_addr);
        end
        serve(ok);
        void'(pop_exp());
        do_ack(1'b1, 1'b1, 32'h3);
        tests++;
        if (!ok || imem_addr !== 32'h24 || retired !== exp_retired) begin
            fails++;
            $display("FAIL br_forward got addr=%h ret=%0d want 24 %0d", imem_addr, retired, exp_retired);
        end
    endtask

    task automatic test_wrap();
        tests++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_req got req=%b addr=%h want 1 fffffffc", w_imem_req, w_imem_addr);
        end
        w_imem_ready = 1'b1; w_imem_rdata = 32'h8C02_0004;
        @(negedge clk);
        w_imem_ready = 1'b0;
        tests++;
        if (w_instr_valid !== 1'b1 || w_instr !== 32'h8C02_0004 || w_pc_out !== 32'hFFFF_FFFC ||
            w_pcplus4 !== 32'h0) begin
            fails++;
            $display("FAIL wrap_present got v=%b instr=%h pc=%h p4=%h want 1 8c020004 fffffffc 0",
                     w_instr_valid, w_instr, w_pc_out, w_pcplus4);
        end
        w_instr_ack = 1'b1; w_branch = 1'b0; w_zero = 1'b1; w_branch_offset = 32'h10;
        @(negedge clk);
        w_instr_ack = 1'b0; w_zero = 1'b0; w_branch_offset = 32'h0;
        tests++;
        if (w_imem_addr !== 32'h0 || w_imem_req !== 1'b1 || w_retired !== 32'd1 || w_pcplus4 !== 32'h4) begin
            fails++;
            $display("FAIL wrap_next got addr=%h req=%b ret=%0d p4=%h want 0 1 1 4",
                     w_imem_addr, w_imem_req, w_retired, w_pcplus4);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit   ok;
        exp_t e;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
            fails++;
            $display("FAIL rst_pre got req=%b addr=%h want 1 24", imem_req, imem_addr);
        end
        reset = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b0 || retired !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
            instr !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid got v=%b ret=%0d req=%b addr=%h instr=%h want 0 0 0 0 0",
                     instr_valid, retired, imem_req, imem_addr, instr);
        end
        reset = 1'b0;
        imem_ready = 1'b0;
        exp_retired = 32'd0;
        exp_q.delete();
        @(negedge clk);
        serve(ok);
        e = pop_exp();
        tests++;
        if (!ok || e.pc !== 32'h0 || instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_refetch got ok=%0d from=%h instr=%h v=%b want 1 0 20080005 1",
                     ok, e.pc, instr, instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_wait_states();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
